tx_switch: RTL and testbench

Ultrasound transmit pulse sequencer for an 8-channel pulser front end. On a single-cycle START it waits a programmable initial delay, drives all channels with a transmit burst of programmable length, then actively clamps (damps) them for a programmable time before returning to idle. It sits between the acquisition controller (which issues START and lengths) and the pulser driver pins TXP/TXN.

---
 rtl/tx_switch_pkg.sv | 19 +
 rtl/tx_phase_cnt.sv | 41 ++++
 rtl/tx_switch.sv | 181 ++++++++++++++++++
 tb/tb_tx_switch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_switch_pkg.sv
// Shared types and constants for the tx_switch transmit pulse sequencer.
// Holds the sequencer state enum, default widths and the per-channel
// drive level constants used by tx_switch and tx_phase_cnt.
package tx_switch_pkg;

  localparam int REG_WIDTH_DEF = 8;
  localparam int NUM_CH_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    TX    = 2'd2,
    DAMP  = 2'd3
  } state_e;

  localparam logic [NUM_CH_DEF-1:0] CH_ALL_ONES = '1;
  localparam logic [NUM_CH_DEF-1:0] CH_ALL_ZERO = '0;

endpackage

// File: rtl/tx_phase_cnt.sv
// Loadable down-counter shared by the DELAY, TX and DAMP phases.
// A load takes priority over a decrement, and the count saturates at
// zero so it never wraps. zero_o reflects the registered count.
module tx_phase_cnt
  import tx_switch_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload for a new phase, otherwise step down towards zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tx_switch.sv
// Ultrasound transmit pulse sequencer: on START it waits init_delay cycles,
// drives a tx_len cycle burst on every channel, then clamps all channels for
// damp_len cycles before returning to idle. Outputs are registered from the
// next state so TXP/TXN track the sequencer state cycle for cycle.
// Build option: define TX_SWITCH_BIPOLAR_EN for an alternating P/N burst;
// without it the burst is unipolar (TXP high, TXN low for every TX cycle).
module tx_switch
  import tx_switch_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int NUM_CH    = NUM_CH_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [REG_WIDTH-1:0] init_delay,
  input  logic [REG_WIDTH-1:0] tx_len,
  input  logic [REG_WIDTH-1:0] damp_len,
  output logic [NUM_CH-1:0]    TXP,
  output logic [NUM_CH-1:0]    TXN
);

  // The package drive levels are replicated to the configured channel count.
  localparam logic [NUM_CH-1:0] ChOnes = {NUM_CH{CH_ALL_ONES[0]}};
  localparam logic [NUM_CH-1:0] ChZero = {NUM_CH{CH_ALL_ZERO[0]}};

  state_e                 state_q;
  state_e                 state_d;
  logic [REG_WIDTH-1:0]   txLen_q;
  logic [REG_WIDTH-1:0]   txLen_d;
  logic [REG_WIDTH-1:0]   dampLen_q;
  logic [REG_WIDTH-1:0]   dampLen_d;
  logic [NUM_CH-1:0]      txp_q;
  logic [NUM_CH-1:0]      txp_d;
  logic [NUM_CH-1:0]      txn_q;
  logic [NUM_CH-1:0]      txn_d;

  logic                   cntLoad;
  logic [REG_WIDTH-1:0]   cntLoadVal;
  logic                   cntDec;
  logic                   cntZero;

  // One counter times every phase; the FSM reloads it on each phase entry.
  tx_phase_cnt #(
    .WIDTH(REG_WIDTH)
  ) u_phase_cnt (
    .clk_i    (CLK),
    .rst_n_i  (RESET),
    .load_i   (cntLoad),
    .loadVal_i(cntLoadVal),
    .dec_i    (cntDec),
    .zero_o   (cntZero)
  );

  // Next-state logic: the acceptance cycle plus init_delay cycles are spent
  // in DELAY, then TX and DAMP each run for their captured length, and any
  // zero-length phase is skipped straight through to the following one.
  always_comb begin
    state_d    = state_q;
    txLen_d    = txLen_q;
    dampLen_d  = dampLen_q;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = DELAY;
          txLen_d    = tx_len;
          dampLen_d  = damp_len;
          cntLoad    = 1'b1;
          cntLoadVal = init_delay;
        end
      end
      DELAY: begin
        if (!cntZero) begin
          cntDec = 1'b1;
        end else if (txLen_q != '0) begin
          state_d    = TX;
          cntLoad    = 1'b1;
          cntLoadVal = txLen_q - REG_WIDTH'(1);
        end else if (dampLen_q != '0) begin
          state_d    = DAMP;
          cntLoad    = 1'b1;
          cntLoadVal = dampLen_q - REG_WIDTH'(1);
        end else begin
          state_d = IDLE;
        end
      end
      TX: begin
        if (!cntZero) begin
          cntDec = 1'b1;
        end else if (dampLen_q != '0) begin
          state_d    = DAMP;
          cntLoad    = 1'b1;
          cntLoadVal = dampLen_q - REG_WIDTH'(1);
        end else begin
          state_d = IDLE;
        end
      end
      DAMP: begin
        if (!cntZero) begin
          cntDec = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef TX_SWITCH_BIPOLAR_EN
  logic oddCycle_q;
  logic oddCycle_d;

  // Burst parity: first TX cycle is even, each further TX cycle flips it.
  always_comb begin
    oddCycle_d = 1'b0;
    if ((state_q == TX) && (state_d == TX)) begin
      oddCycle_d = ~oddCycle_q;
    end
  end

  // Parity register, cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      oddCycle_q <= 1'b0;
    end else begin
      oddCycle_q <= oddCycle_d;
    end
  end
`endif

  // Output decode from the next state; only DAMP drives both rails high.
  always_comb begin
    txp_d = ChZero;
    txn_d = ChZero;
    unique case (state_d)
      TX: begin
`ifdef TX_SWITCH_BIPOLAR_EN
        txp_d = oddCycle_d ? ChZero : ChOnes;
        txn_d = oddCycle_d ? ChOnes : ChZero;
`else
        txp_d = ChOnes;
        txn_d = ChZero;
`endif
      end
      DAMP: begin
        txp_d = ChOnes;
        txn_d = ChOnes;
      end
      default: begin
        txp_d = ChZero;
        txn_d = ChZero;
      end
    endcase
  end

  // State, captured lengths and output registers; reset forces idle high-Z.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      txLen_q   <= '0;
      dampLen_q <= '0;
      txp_q     <= '0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      txLen_q   <= txLen_d;
      dampLen_q <= dampLen_d;
      txp_q     <= txp_d;
      txn_q     <= txn_d;
    end
  end

  assign TXP = txp_q;
  assign TXN = txn_q;

endmodule

// File: tb/tb_tx_switch.sv
// Self-checking bench for tx_switch. A reference model keeps the accepted
// START edge and the captured lengths and derives the expected TXP/TXN after
// every edge from the phase windows of the transmit sequence.
module tb_tx_switch;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] init_delay;
  logic [7:0] tx_len;
  logic [7:0] damp_len;
  logic [7:0] TXP;
  logic [7:0] TXN;

  int compareCount;
  int mismatchCount;

  int edgeN;
  int e0;
  int mD;
  int mT;
  int mM;
  int idleFrom;
  bit active;

  tx_switch dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .init_delay(init_delay),
    .tx_len    (tx_len),
    .damp_len  (damp_len),
    .TXP       (TXP),
    .TXN       (TXN)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Guard against a run that never finishes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time (got running, expected done)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model update for one rising edge: a START seen while the block is idle
  // starts a sequence. The block is idle again after edge E0+1+D+T+M.
  task automatic modelEdge(input logic st);
    edgeN++;
    if (st && (edgeN >= idleFrom)) begin
      active   = 1'b1;
      e0       = edgeN;
      mD       = int'(init_delay);
      mT       = int'(tx_len);
      mM       = int'(damp_len);
      idleFrom = e0 + mD + mT + mM + 2;
    end
  endtask

  task automatic modelReset();
    active   = 1'b0;
    idleFrom = 0;
  endtask

  // Compare the outputs with the phase the model says this edge falls in.
  task automatic checkOutput(input string tag);
    logic [7:0] expP;
    logic [7:0] expN;
    int j;
    int k;
    expP = 8'h00;
    expN = 8'h00;
    if (active) begin
      j = edgeN - e0;
      if ((j >= 1 + mD) && (j <= mD + mT)) begin
        k = j - 1 - mD;
`ifdef TX_SWITCH_BIPOLAR_EN
        expP = (k % 2 == 0) ? 8'hFF : 8'h00;
        expN = (k % 2 == 0) ? 8'h00 : 8'hFF;
`else
        expP = 8'hFF;
        expN = 8'h00;
        if (k < 0) expP = 8'h00;
`endif
      end else if ((j >= mD + mT + 1) && (j <= mD + mT + mM)) begin
        expP = 8'hFF;
        expN = 8'hFF;
      end
    end
    compareCount++;
    assert (TXP === expP) else begin
      mismatchCount++;
      $error("[TB] FAIL %s TXP at edge %0d: got %b expected %b", tag, edgeN, TXP, expP);
    end
    compareCount++;
    assert (TXN === expN) else begin
      mismatchCount++;
      $error("[TB] FAIL %s TXN at edge %0d: got %b expected %b", tag, edgeN, TXN, expN);
    end
  endtask

  // Drive START for one cycle, advance the model on the edge, check after it.
  task automatic applyStimulus(input logic st, input string tag);
    START = st;
    @(posedge CLK);
    modelEdge(st);
    #1;
    checkOutput(tag);
  endtask

  task automatic runUntilIdle(input string tag);
    while (edgeN < idleFrom) begin
      applyStimulus(1'b0, tag);
    end
    applyStimulus(1'b0, tag);
  endtask

  task automatic setLengths(input int d, input int t, input int m);
    init_delay = 8'(d);
    tx_len     = 8'(t);
    damp_len   = 8'(m);
  endtask

  initial begin
    int rd;
    int rt;
    int rm;
    compareCount  = 0;
    mismatchCount = 0;
    edgeN         = 0;
    e0            = 0;
    mD            = 0;
    mT            = 0;
    mM            = 0;
    modelReset();

    // Reset state.
    RESET = 1'b0;
    START = 1'b0;
    setLengths(0, 0, 0);
    #1;
    checkOutput("reset");
    #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, "idle");

    // Nominal sequence D=5 T=7 M=3.
    setLengths(5, 7, 3);
    applyStimulus(1'b1, "nominal");
    runUntilIdle("nominal");

    // Zero delay and damp, then all-zero lengths.
    setLengths(0, 4, 0);
    applyStimulus(1'b1, "zero_dm");
    runUntilIdle("zero_dm");
    setLengths(0, 0, 0);
    applyStimulus(1'b1, "zero_all");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, "zero_all");

    // Second START mid-burst is ignored.
    setLengths(5, 7, 3);
    applyStimulus(1'b1, "busy");
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, "busy");
    applyStimulus(1'b1, "busy_start");
    runUntilIdle("busy");

    // Length inputs changed after acceptance only affect the next START.
    setLengths(2, 7, 2);
    applyStimulus(1'b1, "len_change");
    setLengths(1, 3, 5);
    runUntilIdle("len_change");
    applyStimulus(1'b1, "len_next");
    runUntilIdle("len_next");

    // Reset in the middle of a burst clears the outputs without a clock edge.
    setLengths(2, 9, 3);
    applyStimulus(1'b1, "mid_reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, "mid_reset");
    #2;
    RESET = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    applyStimulus(1'b0, "in_reset");
    applyStimulus(1'b0, "in_reset");
    #3;
    RESET = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, "after_reset");

    // Longest burst the count width allows.
    setLengths(1, 255, 2);
    applyStimulus(1'b1, "max_tx");
    runUntilIdle("max_tx");

    // Randomized sequences with stray START pulses and length changes.
    for (int it = 0; it < 25; it++) begin
      rd = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 10));
      rt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 12));
      rm = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 8));
      setLengths(rd, rt, rm);
      applyStimulus(1'b1, "random");
      while (edgeN < idleFrom) begin
        if ($urandom_range(0, 5) == 0) begin
          setLengths(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 20)));
        end
        applyStimulus(((edgeN + 2) < idleFrom) && ($urandom_range(0, 7) == 0), "random");
      end
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) applyStimulus(1'b0, "random_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
